// File: rtl/sig_mag_decoder.sv
// Sign/magnitude stream decoder with windowed sig/mag occupancy statistics.
// Define SIGMAG_THR_LOOP_EN to add the quantizer threshold steering loop.
module sig_mag_decoder #(
`ifdef SIGMAG_THR_LOOP_EN
    parameter int               THR_W    = 14,
    parameter logic [THR_W-1:0] THR_INIT = 14'd512,
`endif
    parameter int OUT_W      = 4,
    parameter int MAG_WEIGHT = 3,
    parameter int CNT_W      = 12
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    in_valid,
    input  logic                    sig,
    input  logic                    mag,
    input  logic [CNT_W-1:0]        period_len,
`ifdef SIGMAG_THR_LOOP_EN
    input  logic [CNT_W:0]          mag_target,
    input  logic [THR_W-1:0]        thr_step,
    output logic [THR_W-1:0]        thr_out,
`endif
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    stat_valid,
    output logic [CNT_W:0]          sig_cnt,
    output logic [CNT_W:0]          mag_cnt
);

    localparam logic [CNT_W:0]          CNT_ONE = {{CNT_W{1'b0}}, 1'b1};
    localparam logic signed [OUT_W-1:0] LVL_HI  = OUT_W'(MAG_WEIGHT);
    localparam logic signed [OUT_W-1:0] LVL_LO  = OUT_W'(1);

    // A programmed length of zero stands for the full 2^CNT_W window.
    function automatic logic [CNT_W:0] decode_len(input logic [CNT_W-1:0] p);
        decode_len = (p == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, p};
    endfunction

    logic                    out_valid_q;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;
    logic                    stat_valid_q;
    logic [CNT_W:0]          sig_cnt_q, sig_cnt_d;
    logic [CNT_W:0]          mag_cnt_q, mag_cnt_d;
    logic [CNT_W:0]          win_cnt_q, win_cnt_d;
    logic [CNT_W:0]          sig_acc_q, sig_acc_d;
    logic [CNT_W:0]          mag_acc_q, mag_acc_d;
    logic [CNT_W:0]          len_q, len_d;
    logic                    arm_q;
    logic [CNT_W:0]          len_eff, sig_sum, mag_sum;
    logic signed [OUT_W-1:0] level;
    logic                    close;

    // arm_q marks the first cycle out of reset, where the window length is
    // taken straight from period_len and loaded into the shadow register.
    always_comb begin
        len_eff    = arm_q ? decode_len(period_len) : len_q;
        close      = in_valid && (win_cnt_q == len_eff - CNT_ONE);
        sig_sum    = sig_acc_q + {{CNT_W{1'b0}}, sig};
        mag_sum    = mag_acc_q + {{CNT_W{1'b0}}, mag};
        level      = mag ? LVL_HI : LVL_LO;
        out_data_d = out_data_q;
        win_cnt_d  = win_cnt_q;
        sig_acc_d  = sig_acc_q;
        mag_acc_d  = mag_acc_q;
        sig_cnt_d  = sig_cnt_q;
        mag_cnt_d  = mag_cnt_q;
        len_d      = (arm_q || close) ? decode_len(period_len) : len_q;
        if (in_valid) begin
            out_data_d = sig ? -level : level;
            if (close) begin
                win_cnt_d = '0;
                sig_acc_d = '0;
                mag_acc_d = '0;
                sig_cnt_d = sig_sum;
                mag_cnt_d = mag_sum;
            end else begin
                win_cnt_d = win_cnt_q + CNT_ONE;
                sig_acc_d = sig_sum;
                mag_acc_d = mag_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            stat_valid_q <= 1'b0;
            sig_cnt_q    <= '0;
            mag_cnt_q    <= '0;
            win_cnt_q    <= '0;
            sig_acc_q    <= '0;
            mag_acc_q    <= '0;
            len_q        <= '0;
            arm_q        <= 1'b1;
        end else begin
            out_valid_q  <= in_valid;
            out_data_q   <= out_data_d;
            stat_valid_q <= close;
            sig_cnt_q    <= sig_cnt_d;
            mag_cnt_q    <= mag_cnt_d;
            win_cnt_q    <= win_cnt_d;
            sig_acc_q    <= sig_acc_d;
            mag_acc_q    <= mag_acc_d;
            len_q        <= len_d;
            arm_q        <= 1'b0;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign stat_valid = stat_valid_q;
    assign sig_cnt    = sig_cnt_q;
    assign mag_cnt    = mag_cnt_q;

`ifdef SIGMAG_THR_LOOP_EN
    function automatic logic [THR_W-1:0] thr_adjust(
        input logic [THR_W-1:0] thr,
        input logic [THR_W-1:0] step,
        input logic             up,
        input logic             dn
    );
        logic [THR_W:0] sum;
        sum = {1'b0, thr} + {1'b0, step};
        if (up)
            thr_adjust = sum[THR_W] ? {THR_W{1'b1}} : sum[THR_W-1:0];
        else if (dn)
            thr_adjust = (step > thr) ? '0 : thr - step;
        else
            thr_adjust = thr;
    endfunction

    logic [THR_W-1:0] thr_q, thr_d;

    // Steer on the freshly published window count while the strobe is high.
    always_comb begin
        thr_d = thr_q;
        if (stat_valid_q)
            thr_d = thr_adjust(thr_q, thr_step, mag_cnt_q > mag_target,
                               mag_cnt_q < mag_target);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) thr_q <= THR_INIT;
        else         thr_q <= thr_d;
    end

    assign thr_out = thr_q;
`endif

endmodule

// File: tb/tb_sig_mag_decoder.sv
// Self-checking bench for sig_mag_decoder: vector table, directed window
// sequences and randomized traffic against a sample-list window model.
module tb_sig_mag_decoder;
    localparam int OUT_W = 4;
    localparam int CNT_W = 12;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             in_valid = 1'b0;
    logic             sig = 1'b0;
    logic             mag = 1'b0;
    logic [CNT_W-1:0] period_len = '0;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic             stat_valid;
    logic [CNT_W:0]   sig_cnt;
    logic [CNT_W:0]   mag_cnt;
`ifdef SIGMAG_THR_LOOP_EN
    logic [CNT_W:0]   mag_target = '0;
    logic [13:0]      thr_step = '0;
    logic [13:0]      thr_out;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sig_mag_decoder dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .sig        (sig),
        .mag        (mag),
        .period_len (period_len),
`ifdef SIGMAG_THR_LOOP_EN
        .mag_target (mag_target),
        .thr_step   (thr_step),
        .thr_out    (thr_out),
`endif
        .out_valid  (out_valid),
        .out_data   (out_data),
        .stat_valid (stat_valid),
        .sig_cnt    (sig_cnt),
        .mag_cnt    (mag_cnt)
    );

    // Reference model: expected visible outputs plus the current window
    // as a list of sample bits.
    int m_ov, m_odv, m_sv, m_sc, m_mc, m_len;
    int win_s[$];
    int win_m[$];
`ifdef SIGMAG_THR_LOOP_EN
    int m_thr;
`endif

    typedef struct {
        logic       s;
        logic       m;
        logic [3:0] exp_data;
    } map_vec_t;
    map_vec_t map_tbl[4];

    function automatic int decode_len(input logic [CNT_W-1:0] p);
        return (p == 0) ? 4096 : int'(p);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, out_valid, m_ov);
        chk({tag, ".out_data"}, $signed(out_data), m_odv);
        chk({tag, ".stat_valid"}, stat_valid, m_sv);
        chk({tag, ".sig_cnt"}, sig_cnt, m_sc);
        chk({tag, ".mag_cnt"}, mag_cnt, m_mc);
`ifdef SIGMAG_THR_LOOP_EN
        chk({tag, ".thr_out"}, thr_out, m_thr);
`endif
    endtask

    task automatic model_reset();
        m_ov = 0; m_odv = 0; m_sv = 0; m_sc = 0; m_mc = 0;
        win_s.delete();
        win_m.delete();
        m_len = decode_len(period_len);
`ifdef SIGMAG_THR_LOOP_EN
        m_thr = 512;
`endif
    endtask

    // Starts and ends on a falling edge; asserts resetn asynchronously.
    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        in_valid = 1'b0;
        #2;
        model_reset();
        check_outputs("rst");
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic cycle(input logic v, input logic s, input logic m);
        int lv;
        int sv_next;
        int ssum;
        int msum;
        sv_next = 0;
        in_valid = v; sig = s; mag = m;
`ifdef SIGMAG_THR_LOOP_EN
        if (m_sv != 0) begin
            if (m_mc > int'(mag_target))
                m_thr = (m_thr + int'(thr_step) > 16383) ? 16383 : m_thr + int'(thr_step);
            else if (m_mc < int'(mag_target))
                m_thr = (m_thr < int'(thr_step)) ? 0 : m_thr - int'(thr_step);
        end
`endif
        if (v) begin
            lv = m ? 3 : 1;
            m_odv = s ? -lv : lv;
            win_s.push_back(int'(s));
            win_m.push_back(int'(m));
            if (win_s.size() == m_len) begin
                ssum = 0; msum = 0;
                foreach (win_s[i]) ssum += win_s[i];
                foreach (win_m[i]) msum += win_m[i];
                m_sc = ssum; m_mc = msum;
                win_s.delete();
                win_m.delete();
                m_len = decode_len(period_len);
                sv_next = 1;
            end
        end
        m_ov = int'(v);
        m_sv = sv_next;
        @(posedge clk);
        @(negedge clk);
        check_outputs("cyc");
    endtask

`ifdef SIGMAG_THR_LOOP_EN
    task automatic thr_window(input int n_mag, input int exp_thr, input string name);
        for (int i = 0; i < 200; i++) cycle(1'b1, 1'(i % 2), 1'(i < n_mag));
        cycle(1'b0, 1'b0, 1'b0);
        chk(name, thr_out, exp_thr);
    endtask
`endif

    initial begin
        int first_st;
        int second_st;
        int saw;

        map_tbl[0] = '{1'b0, 1'b0, 4'h1};
        map_tbl[1] = '{1'b0, 1'b1, 4'h3};
        map_tbl[2] = '{1'b1, 1'b0, 4'hF};
        map_tbl[3] = '{1'b1, 1'b1, 4'hD};

        // Mapping table
        period_len = 12'd100;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, map_tbl[i].s, map_tbl[i].m);
            chk("map.data", out_data, map_tbl[i].exp_data);
            chk("map.valid", out_valid, 1);
        end
        cycle(1'b0, 1'b1, 1'b0);
        chk("map.hold", out_data, 4'hD);
        chk("map.novalid", out_valid, 0);

        // Window of 8: sig on 3, mag on 5
        period_len = 12'd8;
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'(i < 3), 1'(i >= 3));
        chk("win8.strobe", stat_valid, 1);
        chk("win8.sig", sig_cnt, 3);
        chk("win8.mag", mag_cnt, 5);
        cycle(1'b0, 1'b0, 1'b0);
        chk("win8.pulse", stat_valid, 0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'(i == 0), 1'b0);
        chk("win8b.sig", sig_cnt, 1);
        chk("win8b.mag", mag_cnt, 0);

        // Gapped input, length change mid-window
        period_len = 12'd4;
        do_reset();
        first_st = -1; second_st = -1; saw = 0;
        for (int c = 0; c < 24; c++) begin
            if (c == 3) period_len = 12'd6;
            cycle(1'(c % 2 == 0), 1'b0, 1'b1);
            if (stat_valid) begin
                if (first_st < 0) first_st = c;
                else if (second_st < 0) second_st = c;
            end
        end
        chk("gap.first", first_st, 6);
        chk("gap.second", second_st, 18);

        // Full 4096 window with all mag set
        period_len = '0;
        do_reset();
        for (int i = 0; i < 4096; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b1);
        chk("full.strobe", stat_valid, 1);
        chk("full.mag", mag_cnt, 4096);

        // Reset in the middle of a window
        for (int i = 0; i < 100; i++) cycle(1'b1, 1'b1, 1'b1);
        do_reset();
        for (int i = 0; i < 50; i++) begin
            cycle(1'b1, 1'b1, 1'b1);
            if (stat_valid) saw = 1;
        end
        chk("midrst.nostrobe", saw, 0);
        chk("midrst.mag", mag_cnt, 0);

        // Randomized traffic
        for (int r = 0; r < 3; r++) begin
            period_len = CNT_W'($urandom_range(1, 20));
            do_reset();
            for (int i = 0; i < 300; i++) begin
                if (i > 0 && $urandom_range(0, 49) == 0)
                    period_len = CNT_W'($urandom_range(1, 20));
`ifdef SIGMAG_THR_LOOP_EN
                mag_target = 13'($urandom_range(0, 20));
                thr_step = 14'($urandom_range(0, 3000));
`endif
                cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
            end
        end

`ifdef SIGMAG_THR_LOOP_EN
        // Threshold loop steering and saturation
        period_len = 12'd200;
        mag_target = 13'd100;
        thr_step = 14'd16;
        do_reset();
        chk("thr.init", thr_out, 512);
        thr_window(150, 528, "thr.up");
        thr_window(50, 512, "thr.down");
        thr_step = 14'd504;
        thr_window(50, 8, "thr.to8");
        thr_step = 14'd16;
        thr_window(50, 0, "thr.sat0");
        thr_window(100, 0, "thr.hold");
        thr_step = 14'd16383;
        thr_window(200, 16383, "thr.satmax");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
